carry_lookahead_adder: RTL and testbench
========================================

Name: carry_lookahead_adder

Overview:
Parameterised carry-lookahead adder computing a + b + cin, with a registered result (sum, cout).
The default WIDTH=4 configuration is the 4-bit CLA used as a datapath arithmetic primitive.
Carries are produced by two-level lookahead: per-bit generate/propagate, 4-bit group lookahead, then group-level lookahead across groups.
It is not a ripple chain.

Parameters:
WIDTH, 4, operand and sum width in bits; must be a positive multiple of 4 (elaboration error otherwise).

Ports:
clk  input  1  clock; all registers update on the rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies a, b, cin this cycle.
a  input  WIDTH  operand A, unsigned.
b  input  WIDTH  operand B, unsigned.
cin  input  1  carry into bit 0.
sum  output  WIDTH  registered (a + b + cin) mod 2^WIDTH.
cout  output  1  registered carry out of bit WIDTH-1.
out_valid  output  1  registered in_valid; marks sum/cout as belonging to a qualified input.

Behaviour:
- Reset: while rst=1, asynchronously and immediately force sum=0, cout=0, out_valid=0. Release is synchronous to the next clk edge.
- Per bit i: g_i = a_i & b_i; p_i = a_i ^ b_i.
- Carry recurrence: c_{i+1} = g_i | (p_i & c_i), with c_0 = cin. Implement it in expanded lookahead form, not as a ripple chain.
- 4-bit group k:
  - Group generate G_k = g3 | p3g2 | p3p2g1 | p3p2p1g0.
  - Group propagate P_k = p3p2p1p0.
  - Internal carries come from the group carry-in via the expanded equations.
- Group carries: C_{k+1} = G_k | (P_k & C_k), with C_0 = cin. Also in expanded lookahead form across all groups.
- sum_i = p_i ^ c_i; cout = c_WIDTH.
- Latency: exactly 1 clk. Inputs sampled at edge N appear on sum/cout/out_valid after edge N.
- Registers capture a, b, cin every cycle, regardless of in_valid. out_valid <= in_valid.
- Throughput: one addition per clock, no stalls, no backpressure.
- Arithmetic is unsigned and modular. Overflow is reported only via cout; there is no signed-overflow flag.
- Boundaries:
  - All-ones + all-ones + 1 yields sum all-ones, cout=1.
  - Full propagate chain (a ^ b all ones, cin=1) yields sum 0, cout=1.
- Reset mid-operation: the result of any in-flight sample is discarded; outputs hold 0 until the first edge after rst deasserts.
- X on inputs with in_valid=0 must not affect out_valid.

Decomposition:
- Shared package cla_pkg: localparam CLA_GROUP_W=4; a function returning the group count (WIDTH/4).
- Sub-module cla_group4: combinational; inputs a[3:0], b[3:0], ci; outputs s[3:0], G, P.
- Top level:
  - instantiates WIDTH/4 cla_group4 via generate;
  - computes group carries with lookahead logic;
  - holds the output registers.

Test Plan:
- a=0000, b=0000, cin=0, in_valid=1 -> next cycle sum=0000, cout=0, out_valid=1.
- a=0001, b=0010, cin=0 -> sum=0011, cout=0.
- a=1111, b=0001, cin=0 -> sum=0000, cout=1 (full carry propagation).
- a=1010, b=0101, cin=1 -> sum=0000, cout=1 (all-propagate path driven by cin).
- a=1111, b=1111, cin=1 -> sum=1111, cout=1. Then exhaustive sweep of all 512 input combinations against a behavioural a+b+cin model, one per clock, checking the 1-cycle latency.
- Assert rst mid-stream (asynchronously, between edges) -> sum=0, cout=0, out_valid=0 immediately, independent of clk. Repeat the sweep with WIDTH=16 using random vectors plus 0xFFFF+0x0001+0 -> sum=0x0000, cout=1.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared constants and helpers for the carry-lookahead adder.
package cla_pkg;

    localparam int CLA_GROUP_W = 4;

    function automatic int cla_groups(input int width);
        return width / CLA_GROUP_W;
    endfunction

endpackage

// File: rtl/cla_group4.sv
// One 4-bit lookahead group: sum bits from the group carry-in, plus group G/P for the next level.
module cla_group4
    import cla_pkg::*;
(
    input  logic [CLA_GROUP_W-1:0] a,
    input  logic [CLA_GROUP_W-1:0] b,
    input  logic                   ci,
    output logic [CLA_GROUP_W-1:0] s,
    output logic                   G,
    output logic                   P
);

    logic [CLA_GROUP_W-1:0] g;
    logic [CLA_GROUP_W-1:0] p;
    logic                   c1;
    logic                   c2;
    logic                   c3;

    assign g = a & b;
    assign p = a ^ b;

    // G/P depend only on a and b, so the top-level carry network sees no path through ci.
    assign G = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    assign P = p[3] & p[2] & p[1] & p[0];

    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/carry_lookahead_adder.sv
// Two-level carry-lookahead adder (4-bit groups, flat group-carry lookahead) with a registered result.
module carry_lookahead_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    localparam int NG = cla_groups(WIDTH);

    if (WIDTH <= 0 || (WIDTH % CLA_GROUP_W) != 0) begin : g_width_check
        $error("carry_lookahead_adder: WIDTH must be a positive multiple of 4");
    end

    logic [NG-1:0]    grp_g;
    logic [NG-1:0]    grp_p;
    logic [NG:0]      grp_c;
    logic [WIDTH-1:0] sum_p0;
    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             vld_p1;

    for (genvar gi = 0; gi < NG; gi++) begin : g_grp
        cla_group4 u_grp (
            .a  (a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .b  (b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .ci (grp_c[gi]),
            .s  (sum_p0[gi*CLA_GROUP_W +: CLA_GROUP_W]),
            .G  (grp_g[gi]),
            .P  (grp_p[gi])
        );
    end

    // Each group carry is a flat OR of products over all lower groups and cin, not a chain.
    always_comb begin
        logic acc;
        logic term;
        grp_c    = '0;
        grp_c[0] = cin;
        for (int k = 1; k <= NG; k++) begin
            term = cin;
            for (int j = 0; j < k; j++) term = term & grp_p[j];
            acc = term;
            for (int j = 0; j < k; j++) begin
                term = grp_g[j];
                for (int m = j + 1; m < k; m++) term = term & grp_p[m];
                acc = acc | term;
            end
            grp_c[k] = acc;
        end
    end

    // p0 -> p1: result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            sum_p1  <= sum_p0;
            cout_p1 <= grp_c[NG];
            vld_p1  <= in_valid;
        end
    end

    assign sum       = sum_p1;
    assign cout      = cout_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_carry_lookahead_adder.sv
// Directed and sweep bench for the 4-bit and 16-bit adder configurations.
module tb_carry_lookahead_adder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        v4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic        c4;
    logic [3:0]  s4;
    logic        co4;
    logic        ov4;

    logic        v16;
    logic [15:0] a16;
    logic [15:0] b16;
    logic        c16;
    logic [15:0] s16;
    logic        co16;
    logic        ov16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    carry_lookahead_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .a(a4), .b(b4), .cin(c4),
        .sum(s4), .cout(co4), .out_valid(ov4)
    );

    carry_lookahead_adder #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(v16), .a(a16), .b(b16), .cin(c16),
        .sum(s16), .cout(co16), .out_valid(ov16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // exp is {cout, sum}; out_valid is expected high
    task automatic step4(input logic [3:0] a, input logic [3:0] b, input logic c,
                         input logic [4:0] exp, input string tag);
        @(negedge clk);
        a4 = a; b4 = b; c4 = c; v4 = 1'b1;
        @(posedge clk);
        #1;
        check(tag, {26'b0, ov4, co4, s4}, {26'b0, 1'b1, exp});
    endtask

    task automatic step16(input logic [15:0] a, input logic [15:0] b, input logic c,
                          input logic [16:0] exp, input string tag);
        @(negedge clk);
        a16 = a; b16 = b; c16 = c; v16 = 1'b1;
        @(posedge clk);
        #1;
        check(tag, {14'b0, ov16, co16, s16}, {14'b0, 1'b1, exp});
    endtask

    initial begin
        logic [4:0]  r4;
        logic [16:0] r16;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rc;

        v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;

        #2;
        check("reset4", {26'b0, ov4, co4, s4}, 32'h0);
        check("reset16", {14'b0, ov16, co16, s16}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        step4(4'b0000, 4'b0000, 1'b0, 5'b0_0000, "zero");
        step4(4'b0001, 4'b0010, 1'b0, 5'b0_0011, "one_plus_two");
        step4(4'b1111, 4'b0001, 1'b0, 5'b1_0000, "full_carry");
        step4(4'b1010, 4'b0101, 1'b1, 5'b1_0000, "all_prop_cin");
        step4(4'b1111, 4'b1111, 1'b1, 5'b1_1111, "all_ones");

        for (int i = 0; i < 512; i++) begin
            logic [8:0] iv;
            iv = 9'(i);
            r4 = {1'b0, iv[8:5]} + {1'b0, iv[4:1]} + {4'b0, iv[0]};
            step4(iv[8:5], iv[4:1], iv[0], r4, "sweep4");
        end

        // asynchronous reset between edges
        step4(4'b0111, 4'b0001, 1'b0, 5'b0_1000, "pre_rst");
        #2;
        rst = 1'b1;
        #1;
        check("rst_async4", {26'b0, ov4, co4, s4}, 32'h0);
        check("rst_async16", {14'b0, ov16, co16, s16}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hold", {26'b0, ov4, co4, s4}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_release", {26'b0, ov4, co4, s4}, {26'b0, 6'b1_0_1000});

        @(negedge clk);
        v4 = 1'b0; a4 = 'x; b4 = 'x; c4 = 1'bx;
        @(posedge clk);
        #1;
        check("x_invalid4", {31'b0, ov4}, 32'h0);
        v4 = 1'b0; a4 = '0; b4 = '0; c4 = 1'b0;

        step16(16'hFFFF, 16'h0001, 1'b0, 17'h1_0000, "w16_ffff_1");
        step16(16'hFFFF, 16'hFFFF, 1'b1, 17'h1_FFFF, "w16_all_ones");
        step16(16'hAAAA, 16'h5555, 1'b1, 17'h1_0000, "w16_all_prop");
        step16(16'h1234, 16'h4321, 1'b0, 17'h0_5555, "w16_plain");
        step16(16'h0FFF, 16'h0001, 1'b0, 17'h0_1000, "w16_group_carry");

        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            r16 = {1'b0, ra} + {1'b0, rb} + {16'b0, rc};
            step16(ra, rb, rc, r16, "rand16");
        end

        @(negedge clk);
        v16 = 1'b0; a16 = 'x; b16 = 'x; c16 = 1'bx;
        @(posedge clk);
        #1;
        check("x_invalid16", {31'b0, ov16}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
